// File: rtl/pc_sequencer.sv
// Program-counter owner for the single-cycle core: picks the next-PC mux select,
// handles stall/halt/resume, traps misaligned targets and counts retired instructions.
module pc_sequencer #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic             i_jalr,
    input  logic             i_halt_req,
    input  logic             i_resume,
    input  logic [N-1:0]     i_branch_target,
    input  logic [N-1:0]     i_jalr_target,
    output logic [N-1:0]     o_pc,
    output logic [1:0]       o_pc_src_sel,
    output logic             o_halted,
    output logic             o_fault,
    output logic [N-1:0]     o_fault_pc,
    output logic [CNT_W-1:0] o_retired_count,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_JALR = 2'b01;
    localparam logic [1:0] SEL_BR   = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    state_t           r_state;
    state_t           w_next_state;
    logic [N-1:0]     r_pc;
    logic [N-1:0]     r_fault_pc;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_sel;
    logic             w_count_en;
    logic             w_capture;
    logic             w_misaligned;
    logic [N-1:0]     w_next_pc;

    // Only the path that would actually be taken is checked; jalr wins over branch.
    assign w_misaligned = i_jalr ? i_jalr_target[1]
                                 : (i_branch_taken && (i_branch_target[1:0] != 2'b00));

    always_comb begin
        w_next_state = r_state;
        w_sel        = SEL_HOLD;
        w_count_en   = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (i_stall) begin
                    w_sel = SEL_HOLD;
                end else if (w_misaligned) begin
                    w_sel        = SEL_HOLD;
                    w_next_state = ST_FAULT;
                    w_capture    = 1'b1;
                end else if (i_halt_req) begin
                    w_sel        = SEL_HOLD;
                    w_next_state = ST_HALTED;
                    w_count_en   = 1'b1;
                end else if (i_jalr) begin
                    w_sel      = SEL_JALR;
                    w_count_en = 1'b1;
                end else if (i_branch_taken) begin
                    w_sel      = SEL_BR;
                    w_count_en = 1'b1;
                end else begin
                    w_sel      = SEL_PC4;
                    w_count_en = 1'b1;
                end
            end
            ST_HALTED: begin
                if (i_resume) begin
                    w_sel        = SEL_PC4;
                    w_next_state = ST_RUN;
                end
            end
            ST_FAULT: begin
                w_sel = SEL_HOLD;
            end
            default: begin
                w_sel        = SEL_HOLD;
                w_next_state = ST_FAULT;
            end
        endcase
    end

    always_comb begin
        w_next_pc = r_pc;
        unique case (w_sel)
            SEL_PC4:  w_next_pc = r_pc + N'(4);
            SEL_BR:   w_next_pc = i_branch_target;
            SEL_JALR: w_next_pc = i_jalr_target;
            default:  w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_fault_pc <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_capture) begin
                r_fault_pc <= r_pc;
            end
            // Saturate instead of wrapping so a long run never reports a small count.
            if (w_count_en && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_src_sel    = w_sel;
    assign o_halted        = (r_state == ST_HALTED);
    assign o_fault         = (r_state == ST_FAULT);
    assign o_fault_pc      = r_fault_pc;
    assign o_retired_count = r_count;
    assign o_state         = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: main 32-bit instance, a 4-bit-counter instance
// for saturation and a RESET_PC=FFFF_FFFC instance for PC+4 wrap-around.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic        jalr;
  logic        halt_req;
  logic        resume;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;

  logic [31:0] pc, fault_pc, cnt;
  logic [1:0]  sel, state;
  logic        halted, fault;

  logic [31:0] pc4, fault_pc4;
  logic [3:0]  cnt4;
  logic [1:0]  sel4, state4;
  logic        halted4, fault4;

  logic [31:0] pcw, fault_pcw, cntw;
  logic [1:0]  selw, statew;
  logic        haltedw, faultw;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.N(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_taken(branch_taken),
    .i_jalr(jalr), .i_halt_req(halt_req), .i_resume(resume),
    .i_branch_target(branch_target), .i_jalr_target(jalr_target),
    .o_pc(pc), .o_pc_src_sel(sel), .o_halted(halted), .o_fault(fault),
    .o_fault_pc(fault_pc), .o_retired_count(cnt), .o_state(state)
  );

  pc_sequencer #(.N(32), .RESET_PC(32'h0), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_taken(branch_taken),
    .i_jalr(jalr), .i_halt_req(halt_req), .i_resume(resume),
    .i_branch_target(branch_target), .i_jalr_target(jalr_target),
    .o_pc(pc4), .o_pc_src_sel(sel4), .o_halted(halted4), .o_fault(fault4),
    .o_fault_pc(fault_pc4), .o_retired_count(cnt4), .o_state(state4)
  );

  pc_sequencer #(.N(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_taken(branch_taken),
    .i_jalr(jalr), .i_halt_req(halt_req), .i_resume(resume),
    .i_branch_target(branch_target), .i_jalr_target(jalr_target),
    .o_pc(pcw), .o_pc_src_sel(selw), .o_halted(haltedw), .o_fault(faultw),
    .o_fault_pc(fault_pcw), .o_retired_count(cntw), .o_state(statew)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jalr = 0; halt_req = 0; resume = 0;
    branch_target = 32'h0; jalr_target = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    do_reset();

    // reset state
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_count", cnt, 0);
    check_eq("rst_fault_pc", fault_pc, 0);
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_wrap_pc", pcw, 32'hFFFF_FFFC);
    check_eq("seq_sel0", sel, 2'b00);

    // sequential PC+4
    tick(); check_eq("seq_pc4", pc, 32'h4); check_eq("wrap_pc0", pcw, 32'h0);
    check_eq("seq_sel1", sel, 2'b00);
    tick(); check_eq("seq_pc8", pc, 32'h8);
    tick(); check_eq("seq_pcC", pc, 32'hC); check_eq("seq_cnt3", cnt, 3);
    tick(); check_eq("seq_pc10", pc, 32'h10); check_eq("seq_cnt4", cnt, 4);

    // branch then jalr
    branch_taken = 1; branch_target = 32'h40; #1;
    check_eq("br_sel", sel, 2'b10);
    tick(); check_eq("br_pc", pc, 32'h40);
    branch_taken = 0; jalr = 1; jalr_target = 32'h100; #1;
    check_eq("jalr_sel", sel, 2'b01);
    tick(); check_eq("jalr_pc", pc, 32'h100); check_eq("jalr_cnt", cnt, 6);
    jalr = 0;

    // stall with branch pending
    branch_taken = 1; branch_target = 32'h20;
    tick(); check_eq("to20_pc", pc, 32'h20);
    stall = 1; branch_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1; check_eq("stall_sel", sel, 2'b11);
      tick(); check_eq("stall_pc", pc, 32'h20); check_eq("stall_cnt", cnt, 7);
    end
    stall = 0;
    tick(); check_eq("unstall_pc", pc, 32'h80); check_eq("unstall_cnt", cnt, 8);

    // halt / resume
    branch_target = 32'h30;
    tick(); check_eq("to30_pc", pc, 32'h30);
    branch_taken = 0; halt_req = 1; #1;
    check_eq("halt_sel", sel, 2'b11);
    tick(); check_eq("halt_halted", halted, 1); check_eq("halt_cnt", cnt, 10);
    halt_req = 0; branch_taken = 1; branch_target = 32'h44; jalr = 1; jalr_target = 32'h88;
    for (int i = 0; i < 5; i++) begin
      #1; check_eq("halted_sel", sel, 2'b11);
      tick(); check_eq("halted_pc", pc, 32'h30); check_eq("halted_cnt", cnt, 10);
    end
    idle_inputs(); resume = 1; #1;
    check_eq("resume_sel", sel, 2'b00);
    tick(); check_eq("resume_pc", pc, 32'h34); check_eq("resume_halted", halted, 0);
    check_eq("resume_cnt", cnt, 10); check_eq("resume_state", state, 2'b00);
    resume = 0;

    // misaligned branch target with branch not taken is ignored
    branch_target = 32'h3; #1;
    check_eq("nt_mis_sel", sel, 2'b00);
    tick(); check_eq("nt_mis_pc", pc, 32'h38); check_eq("nt_mis_fault", fault, 0);

    // misaligned jalr -> fault
    branch_taken = 1; branch_target = 32'h50;
    tick(); check_eq("to50_pc", pc, 32'h50); check_eq("to50_cnt", cnt, 12);
    branch_taken = 0; jalr = 1; jalr_target = 32'h102; #1;
    check_eq("fault_sel", sel, 2'b11);
    tick(); check_eq("fault_flag", fault, 1); check_eq("fault_pc", fault_pc, 32'h50);
    check_eq("fault_pc_hold", pc, 32'h50); check_eq("fault_cnt", cnt, 12);
    check_eq("sat_cnt12", cnt4, 4'd12); check_eq("fault_state", state, 2'b10);
    jalr = 0; resume = 1; branch_taken = 1; branch_target = 32'h80;
    for (int i = 0; i < 2; i++) begin
      #1; check_eq("fault_sel_hold", sel, 2'b11);
      tick(); check_eq("fault_pc_stay", pc, 32'h50); check_eq("fault_stay", fault, 1);
    end
    do_reset();
    check_eq("fault_rst_pc", pc, 32'h0); check_eq("fault_rst_flag", fault, 0);
    check_eq("fault_rst_fpc", fault_pc, 32'h0); check_eq("fault_rst_cnt", cnt, 0);

    // jalr beats branch: only jalr target is checked
    jalr = 1; jalr_target = 32'h100; branch_taken = 1; branch_target = 32'h42; #1;
    check_eq("both_sel", sel, 2'b01);
    tick(); check_eq("both_pc", pc, 32'h100); check_eq("both_fault", fault, 0);

    // misaligned branch -> fault with the correct PC captured
    jalr = 0; #1;
    check_eq("br_mis_sel", sel, 2'b11);
    tick(); check_eq("br_mis_fault", fault, 1); check_eq("br_mis_fpc", fault_pc, 32'h100);
    check_eq("br_mis_cnt", cnt, 1);
    do_reset();

    // saturation on the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) check_eq("sat_cnt14", cnt4, 4'hE);
      if (i == 14) check_eq("sat_cnt15", cnt4, 4'hF);
    end
    check_eq("sat_cnt_final", cnt4, 4'hF);
    check_eq("main_cnt20", cnt, 20);
    check_eq("main_pc20", pc, 32'd80);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
